bit_scan_sequencer: RTL and testbench
=====================================

# bit_scan_sequencer

Sequential scheduler for the 16-bit trailing-zero datapath. Accepts a request vector through a valid/ready load port, then emits the index of every set bit, lowest first, one per handshake on a valid/ready output port. Raises a one-cycle done pulse when the vector is exhausted. Sits between a request-mask producer and any consumer that services requesters in ascending index order.

## Interface
- W, 16, vector width; must be a power of two, at least 2.
- IW, $clog2(W), index width (localparam, not overridable).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- load_valid  in  1  a vector is offered.
- load_ready  out  1  the block accepts a vector; high only in IDLE.
- load_vec  in  W  vector to scan.
- flush  in  1  abort the current scan.
- idx_valid  out  1  idx holds a valid index.
- idx_ready  in  1  the consumer takes idx.
- idx  out  IW  position of the lowest remaining set bit.
- idx_last  out  1  idx is the final index of this vector (IDX_LAST_EN only).
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse after a vector completes.

## Operation
- States: IDLE and SCAN. The working register is vec_r[W-1:0].
- Reset values: state=IDLE, vec_r=0, done=0. Resulting outputs: load_ready=1, idx_valid=0, busy=0, idx=0, idx_last=0.
- IDLE:
  - Asserts load_ready.
  - On load_valid with a non-zero load_vec: vec_r <= load_vec, go to SCAN.
  - On load_valid with load_vec==0: stay in IDLE, done=1 next cycle. No index is emitted.
- SCAN:
  - idx_valid=1.
  - idx = trailing-zero count of vec_r, combinational from the register.
  - On idx_valid & idx_ready: vec_r <= vec_r & (vec_r - 1), which clears the lowest set bit.
  - If the cleared value is 0: go to IDLE, done=1 next cycle.
- Backpressure: while idx_ready=0, idx and idx_last hold stable and vec_r does not change.
- flush:
  - In SCAN: vec_r <= 0, go to IDLE, no done pulse. flush wins over a simultaneous idx handshake; that index is counted as not consumed.
  - In IDLE: flush has priority over load_valid, so no load is accepted that cycle.
- rst at any point, including mid-scan, behaves as flush and also clears done.
- Indices are strictly ascending within a vector. A vector with k set bits produces exactly k handshakes.

## Timing
- Load accepted in cycle N gives idx_valid=1 with the first index in cycle N+1.
- Throughput: one index per cycle while idx_ready=1.
- A vector with k bits, with ready held high and the load in cycle N, produces the last handshake in cycle N+k, done in cycle N+k+1, and load_ready again in cycle N+k+1.
- A zero vector loaded in cycle N produces done in cycle N+1.
- A new load may be accepted in the same cycle as the done pulse.
- done is registered. idx is combinational from vec_r only and never from an input port.

## Configuration
- IDX_LAST_EN defined:
  - idx_last = idx_valid & (vec_r & (vec_r - 1)) == 0.
  - Asserted together with the final index of each vector.
- IDX_LAST_EN undefined:
  - The idx_last port is absent.
  - Consumers rely on done.

## Structure
- Shared package bit_scan_pkg holds:
  - the state enum (IDLE, SCAN);
  - the default width constant 16;
  - a function lowest_clear(v), which returns v & (v - 1).
- One sub-module: lsb_index #(W). Combinational trailing-zero encoder, W-bit in, IW-bit out. An all-zero input returns 0; the sequencer never presents an all-zero value while in SCAN.

## Test plan
- 0x8421 loaded with idx_ready=1 -> idx 0, 5, 10, 15 in four consecutive cycles; idx_last only on 15; done one cycle after 15.
- 0xFFFF -> idx 0 through 15 over 16 cycles; done at load+17; load_ready low throughout the scan.
- 0x0000 -> no idx_valid; done at load+1; load_ready stays 1.
- 0x0110 with idx_ready low for 3 cycles after the first idx_valid -> idx held at 4 across the stall; then 8; then done.
- 0x00F0, flush asserted together with the handshake of idx 5 -> IDLE next cycle, no done, no further indices; the next load of 0x0002 yields idx 1.
- rst pulsed mid-scan of 0xAAAA -> next cycle state IDLE, idx_valid=0, done=0, load_ready=1.

Source files
------------

// File: rtl/bit_scan_sequencer_pkg.sv
// Shared types and helpers for the bit-scan sequencer.
// Holds the FSM state encoding, the default vector width and the lowest-set-bit clear.
package bit_scan_pkg;

  localparam int DEFAULT_W = 16;

  // The helper works on a fixed wide word so any W up to LC_W can share it.
  // Zero-extended operands keep the upper result bits zero.
  localparam int LC_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic [LC_W-1:0] lowest_clear(input logic [LC_W-1:0] v);
    return v & (v - 1'b1);
  endfunction

endpackage

// File: rtl/bit_scan_sequencer_if.sv
// Load / index handshake bundle for bit_scan_sequencer.
// The idx_last wire exists only when IDX_LAST_EN is defined.
interface bit_scan_sequencer_if
  import bit_scan_pkg::*;
#(
  parameter int W = DEFAULT_W
) ();

  localparam int IW = $clog2(W);

  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  load_vec;
  logic          flush;
  logic          idx_valid;
  logic          idx_ready;
  logic [IW-1:0] idx;
`ifdef IDX_LAST_EN
  logic          idx_last;
`endif
  logic          busy;
  logic          done;

`ifdef IDX_LAST_EN
  modport master (
    output load_valid, load_vec, flush, idx_ready,
    input  load_ready, idx_valid, idx, idx_last, busy, done
  );

  modport slave (
    input  load_valid, load_vec, flush, idx_ready,
    output load_ready, idx_valid, idx, idx_last, busy, done
  );
`else
  modport master (
    output load_valid, load_vec, flush, idx_ready,
    input  load_ready, idx_valid, idx, busy, done
  );

  modport slave (
    input  load_valid, load_vec, flush, idx_ready,
    output load_ready, idx_valid, idx, busy, done
  );
`endif

endinterface

// File: rtl/bit_scan_sequencer_lsb_index.sv
// Combinational trailing-zero encoder: index of the lowest set bit of vec.
// An all-zero input encodes as 0.
module lsb_index #(
  parameter int W = 16
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W)-1:0] idx
);

  localparam int IW = $clog2(W);

  // Scanning downward lets the lowest set bit write last and win.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/bit_scan_sequencer.sv
// Emits the index of every set bit of a loaded vector, lowest first, one per handshake.
// Optional build macro: IDX_LAST_EN adds idx_last, flagging the final index of each vector.
module bit_scan_sequencer
  import bit_scan_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input logic                 clk,
  input logic                 rst,
  bit_scan_sequencer_if.slave bus
);

  localparam int IW = $clog2(W);

  state_t         state, state_n;
  logic [W-1:0]   vec_r, vec_n;
  logic           done_r, done_n;
  logic [LC_W-1:0] lc_wide;
  logic           lc_zero;
  logic [IW-1:0]  idx_enc;
  logic           in_scan;

  lsb_index #(.W(W)) u_lsb_index (
    .vec (vec_r),
    .idx (idx_enc)
  );

  assign lc_wide = lowest_clear(LC_W'(vec_r));
  assign lc_zero = (lc_wide == '0);
  assign in_scan = (state == SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      vec_r  <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      vec_r  <= vec_n;
      done_r <= done_n;
    end
  end

  // flush beats both a load and an index handshake in the same cycle.
  always_comb begin
    state_n = state;
    vec_n   = vec_r;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.flush && bus.load_valid) begin
          if (bus.load_vec != '0) begin
            vec_n   = bus.load_vec;
            state_n = SCAN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.flush) begin
          vec_n   = '0;
          state_n = IDLE;
        end else if (bus.idx_ready) begin
          vec_n = lc_wide[W-1:0];
          if (lc_zero) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        vec_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.idx_valid  = in_scan;
  assign bus.busy       = in_scan;
  assign bus.idx        = idx_enc;
  assign bus.done       = done_r;

`ifdef IDX_LAST_EN
  assign bus.idx_last = in_scan & lc_zero;
`endif

endmodule

// File: tb/tb_bit_scan_sequencer.sv
// Directed self-checking bench for bit_scan_sequencer.
// Status word compared each cycle: {load_ready, idx_valid, busy, done, idx[3:0]}.
module tb_bit_scan_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  bit_scan_sequencer_if #(.W(16)) bus ();

  bit_scan_sequencer #(.W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [7:0] status();
    return {bus.load_ready, bus.idx_valid, bus.busy, bus.done, bus.idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    bus.load_valid = 1'b1;
    bus.load_vec   = v;
    tick();
    bus.load_valid = 1'b0;
    bus.load_vec   = '0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_vec   = '0;
    bus.flush      = 1'b0;
    bus.idx_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vecs++;
    if (status() !== 8'b1000_0000) begin
      errs++;
      $display("FAIL reset_state got %b want %b", status(), 8'b1000_0000);
    end
`ifdef IDX_LAST_EN
    vecs++;
    if (bus.idx_last !== 1'b0) begin
      errs++;
      $display("FAIL reset_idx_last got %b want 0", bus.idx_last);
    end
`endif
  endtask

  task automatic test_sparse();
    int ix[4] = '{0, 5, 10, 15};
    bus.idx_ready = 1'b1;
    load(16'h8421);
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (status() !== {4'b0110, 4'(ix[k])}) begin
        errs++;
        $display("FAIL sparse_idx%0d got %b want %b", k, status(), {4'b0110, 4'(ix[k])});
      end
`ifdef IDX_LAST_EN
      vecs++;
      if (bus.idx_last !== (k == 3)) begin
        errs++;
        $display("FAIL sparse_last%0d got %b want %b", k, bus.idx_last, (k == 3));
      end
`endif
      tick();
    end
    vecs++;
    if (status() !== 8'b1001_0000) begin
      errs++;
      $display("FAIL sparse_done got %b want %b", status(), 8'b1001_0000);
    end
    tick();
    vecs++;
    if (status() !== 8'b1000_0000) begin
      errs++;
      $display("FAIL sparse_done_clear got %b want %b", status(), 8'b1000_0000);
    end
  endtask

  task automatic test_full();
    load(16'hFFFF);
    for (int k = 0; k < 16; k++) begin
      vecs++;
      if (status() !== {4'b0110, 4'(k)}) begin
        errs++;
        $display("FAIL full_idx%0d got %b want %b", k, status(), {4'b0110, 4'(k)});
      end
      tick();
    end
    vecs++;
    if (status() !== 8'b1001_0000) begin
      errs++;
      $display("FAIL full_done got %b want %b", status(), 8'b1001_0000);
    end
    tick();
  endtask

  task automatic test_zero();
    load(16'h0000);
    vecs++;
    if (status() !== 8'b1001_0000) begin
      errs++;
      $display("FAIL zero_done got %b want %b", status(), 8'b1001_0000);
    end
    tick();
    vecs++;
    if (status() !== 8'b1000_0000) begin
      errs++;
      $display("FAIL zero_after got %b want %b", status(), 8'b1000_0000);
    end
  endtask

  task automatic test_stall();
    bus.idx_ready = 1'b0;
    load(16'h0110);
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (status() !== 8'b0110_0100) begin
        errs++;
        $display("FAIL stall_hold%0d got %b want %b", k, status(), 8'b0110_0100);
      end
      tick();
    end
    bus.idx_ready = 1'b1;
    vecs++;
    if (status() !== 8'b0110_0100) begin
      errs++;
      $display("FAIL stall_release got %b want %b", status(), 8'b0110_0100);
    end
    tick();
    vecs++;
    if (status() !== 8'b0110_1000) begin
      errs++;
      $display("FAIL stall_second got %b want %b", status(), 8'b0110_1000);
    end
    tick();
    vecs++;
    if (status() !== 8'b1001_0000) begin
      errs++;
      $display("FAIL stall_done got %b want %b", status(), 8'b1001_0000);
    end
    tick();
  endtask

  task automatic test_flush();
    load(16'h00F0);
    vecs++;
    if (status() !== 8'b0110_0100) begin
      errs++;
      $display("FAIL flush_idx4 got %b want %b", status(), 8'b0110_0100);
    end
    tick();
    bus.flush = 1'b1;
    vecs++;
    if (status() !== 8'b0110_0101) begin
      errs++;
      $display("FAIL flush_idx5 got %b want %b", status(), 8'b0110_0101);
    end
    tick();
    bus.flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (status() !== 8'b1000_0000) begin
        errs++;
        $display("FAIL flush_idle%0d got %b want %b", k, status(), 8'b1000_0000);
      end
      tick();
    end
    load(16'h0002);
    vecs++;
    if (status() !== 8'b0110_0001) begin
      errs++;
      $display("FAIL flush_reload got %b want %b", status(), 8'b0110_0001);
    end
    tick();
    vecs++;
    if (status() !== 8'b1001_0000) begin
      errs++;
      $display("FAIL flush_reload_done got %b want %b", status(), 8'b1001_0000);
    end
    tick();
  endtask

  task automatic test_flush_idle();
    bus.flush = 1'b1;
    load(16'h0040);
    bus.flush = 1'b0;
    vecs++;
    if (status() !== 8'b1000_0000) begin
      errs++;
      $display("FAIL flush_blocks_load got %b want %b", status(), 8'b1000_0000);
    end
  endtask

  task automatic test_rst_mid();
    load(16'hAAAA);
    vecs++;
    if (status() !== 8'b0110_0001) begin
      errs++;
      $display("FAIL rst_mid_idx1 got %b want %b", status(), 8'b0110_0001);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if (status() !== 8'b1000_0000) begin
      errs++;
      $display("FAIL rst_mid_state got %b want %b", status(), 8'b1000_0000);
    end
    tick();
    vecs++;
    if (status() !== 8'b1000_0000) begin
      errs++;
      $display("FAIL rst_mid_no_done got %b want %b", status(), 8'b1000_0000);
    end
  endtask

  task automatic test_back_to_back();
    load(16'h0003);
    for (int k = 0; k < 2; k++) begin
      vecs++;
      if (status() !== {4'b0110, 4'(k)}) begin
        errs++;
        $display("FAIL b2b_first%0d got %b want %b", k, status(), {4'b0110, 4'(k)});
      end
      tick();
    end
    vecs++;
    if (status() !== 8'b1001_0000) begin
      errs++;
      $display("FAIL b2b_done got %b want %b", status(), 8'b1001_0000);
    end
    load(16'h0008);
    vecs++;
    if (status() !== 8'b0110_0011) begin
      errs++;
      $display("FAIL b2b_second got %b want %b", status(), 8'b0110_0011);
    end
    tick();
    vecs++;
    if (status() !== 8'b1001_0000) begin
      errs++;
      $display("FAIL b2b_second_done got %b want %b", status(), 8'b1001_0000);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_full();
    test_zero();
    test_stall();
    test_flush();
    test_flush_idle();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
